irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, meaning the number of interrupt source lines; the CPU interface fixes it at 4.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 src  input  N_SRC  raw interrupt request lines, asynchronous to clock; request = rising edge.
REQ-005 ie  input  N_SRC  per-source interrupt enable mask, driven by the CPU's ie output.
REQ-006 ack  input  1  one-cycle interrupt acknowledge pulse from the CPU.
REQ-007 ovr_clr  input  N_SRC  per-bit write-one-to-clear for overrun flags.
REQ-008 irq  output  1  interrupt request to the CPU.
REQ-009 cause  output  2  index of the source taken by the most recent ack; feeds the CPU in port via the board mux.
REQ-010 cause_valid  output  1  high when cause holds a real source; low after a spurious ack.
REQ-011 pending  output  N_SRC  latched, not-yet-acknowledged requests.
REQ-012 overrun  output  N_SRC  sticky flag: an edge arrived while that source was already pending.

Function
REQ-013 Each src bit SHALL pass a 2-flop synchronizer followed by a rising-edge detector: src sampled high at edge N after being low -> edge pulse on the cycle after edge N+1.
REQ-014 An edge pulse on bit i SHALL set pending[i] at the next edge; pending[i] is therefore visible 2 cycles after the src sample.
REQ-015 irq SHALL equal |(pending & ie), combinational from registered pending and the ie input; no extra latency.
REQ-016 ie SHALL only gate irq; masked sources SHALL still set pending and overrun.
REQ-017 On ack, winner = lowest index i with pending[i] & ie[i]; at that edge pending[winner] SHALL clear, cause <= winner, cause_valid <= 1.
REQ-018 On ack with no masked pending bit (spurious), pending SHALL be unchanged, cause <= 0, cause_valid <= 0.
REQ-019 Edge pulse on bit i in the same cycle that ack clears bit i: set SHALL win; pending[i] stays 1 and overrun[i] is not set.
REQ-020 Edge pulse on bit i while pending[i]=1 and not being cleared: overrun[i] SHALL set at the next edge; pending unchanged (no counting).
REQ-021 ovr_clr[i]=1 SHALL clear overrun[i] at the next edge; a simultaneous new overrun event SHALL win (flag stays 1).
REQ-022 cause and cause_valid SHALL hold between acks.
REQ-023 ack is a single-cycle pulse; ack held N cycles SHALL be treated as N acks, each processed on its own edge.
REQ-024 A src level held high SHALL produce exactly one request; a new request requires a low sample first.

Reset
REQ-025 While reset=1 at an edge, the synchronizer flops, edge-detect history, pending, overrun, cause and cause_valid SHALL all go to 0; irq is therefore 0 from the first edge under reset.
REQ-026 A src line already high when reset deasserts SHALL NOT produce a request until it goes low and high again; edge history resets to the synchronized value, not to 0.
REQ-027 Reset during pending/ack activity SHALL discard all state; ack on the reset edge SHALL be ignored.

Structure
REQ-028 The source count constant and the cause index type SHALL live in the shared types package/header beside the CPU's types.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, sync_edge, instantiated N_SRC times; priority select and pending/overrun logic stay in irq_ctrl.

Verification
REQ-030 Reset high, then src=4'b0010 pulse with ie=4'b0010 -> pending=4'b0010 two cycles after sample, irq=1; ack -> cause=1, cause_valid=1, pending=0, irq=0.
REQ-031 src edges on bits 3 and 0 same cycle, ie=4'b1111 -> first ack gives cause=0, second ack gives cause=3, then irq=0.
REQ-032 ie=4'b0000, src bit 2 edge -> pending=4'b0100, irq=0; raise ie=4'b0100 -> irq=1 the same cycle.
REQ-033 Two separate edges on bit 1 without ack -> overrun=4'b0010; ovr_clr=4'b0010 -> overrun=0; edge coinciding with the ack that clears bit 1 -> pending[1]=1, overrun[1]=0.
REQ-034 Ack with pending=0 -> cause=0, cause_valid=0, pending unchanged; src held high across reset release -> no pending until a low-then-high sequence.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types for the interrupt controller and the CPU interface.
package irq_ctrl_pkg;

    // Number of interrupt source lines the CPU interface is built around.
    localparam int unsigned IRQ_N_SRC = 4;

    // Width of the cause index reported to the CPU.
    localparam int unsigned CAUSE_W = 2;

    typedef logic [CAUSE_W-1:0] cause_t;

    // Pipeline depth from reset release until the edge detector's history is meaningful.
    localparam int unsigned ARM_W = 3;

endpackage : irq_ctrl_pkg

// File: rtl/irq_ctrl_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one interrupt source line.
module sync_edge
    import irq_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic src,
    output logic edge_c
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [ARM_W-1:0] arm_q,   arm_d;

    // Next-state for the synchronizer chain and edge history; the arm shifter keeps
    // the detector quiet until history holds a real synchronized sample, so a line
    // already high at reset release is not mistaken for a new request.
    always_comb begin
        sync1_d = src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        arm_d   = {arm_q[ARM_W-2:0], 1'b1};
        edge_c  = sync2_q & ~prev_q & arm_q[ARM_W-1];
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
        end
    end

endmodule : sync_edge

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source edges, reports priority cause on CPU ack.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = IRQ_N_SRC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src,
    input  logic [N_SRC-1:0]   ie,
    input  logic               ack,
    input  logic [N_SRC-1:0]   ovr_clr,
    output logic               irq,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_valid,
    output logic [N_SRC-1:0]   pending,
    output logic [N_SRC-1:0]   overrun
);

    logic [N_SRC-1:0] edge_vec;

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    cause_t           cause_q,   cause_d;
    logic             cause_valid_q, cause_valid_d;

    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] clr_mask;
    logic             win_found;
    cause_t           win_idx;

    // One synchronizer / edge detector per source line.
    for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
        sync_edge u_sync_edge (
            .clock  (clock),
            .reset  (reset),
            .src    (src[g]),
            .edge_c (edge_vec[g])
        );
    end

    // Priority select and pending/overrun/cause next-state; a new edge beats an ack clear.
    always_comb begin
        masked    = pending_q & ie;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_found = 1'b1;
                win_idx   = cause_t'(i);
            end
        end

        clr_mask = '0;
        if (ack && win_found) begin
            clr_mask = N_SRC'(1) << win_idx;
        end

        pending_d = (pending_q & ~clr_mask) | edge_vec;
        overrun_d = (overrun_q & ~ovr_clr) | (edge_vec & pending_q & ~clr_mask);

        cause_d       = cause_q;
        cause_valid_d = cause_valid_q;
        if (ack) begin
            cause_d       = win_found ? win_idx : cause_t'(0);
            cause_valid_d = win_found;
        end
    end

    // State registers; reset discards everything, including an ack on the reset edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q     <= '0;
            overrun_q     <= '0;
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
        end
    end

    // irq follows ie with no added latency.
    assign irq         = |(pending_q & ie);
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign cause       = cause_q;
    assign cause_valid = cause_valid_q;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl with a behavioural interrupt model.
module tb_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic [3:0] ie;
    logic       ack;
    logic [3:0] ovr_clr;
    logic       irq;
    logic [1:0] cause;
    logic       cause_valid;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] ovr;
        logic [1:0] cause;
        logic       cv;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];

    // Inputs the DUT currently sees (applied before the coming edge).
    logic       c_rst;
    logic [3:0] c_src, c_ie, c_clr;
    logic       c_ack;

    // Reference model state.
    logic [3:0] m_pend, m_ovr;
    logic [1:0] m_cause;
    logic       m_cv;
    logic [3:0] m_prev;
    logic       m_have_prev;
    logic [3:0] rise_hist [2];

    irq_ctrl #(.N_SRC(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .src         (src),
        .ie          (ie),
        .ack         (ack),
        .ovr_clr     (ovr_clr),
        .irq         (irq),
        .cause       (cause),
        .cause_valid (cause_valid),
        .pending     (pending),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Model one rising clock edge: a low-then-high pair of samples is a request that
    // reaches pending two edges after the high sample; ack takes the lowest enabled
    // pending source; a request on a still-pending source is an overrun.
    task automatic model_edge();
        logic [3:0] ev, rise, clr;
        if (c_rst) begin
            m_pend = '0; m_ovr = '0; m_cause = '0; m_cv = 1'b0;
            m_prev = '0; m_have_prev = 1'b0;
            rise_hist[0] = '0; rise_hist[1] = '0;
            return;
        end
        ev   = rise_hist[1];
        rise = m_have_prev ? (c_src & ~m_prev) : 4'b0000;
        rise_hist[1] = rise_hist[0];
        rise_hist[0] = rise;
        m_prev = c_src;
        m_have_prev = 1'b1;

        clr = '0;
        if (c_ack) begin
            m_cause = '0;
            m_cv    = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && c_ie[i] && !m_cv) begin
                    m_cv    = 1'b1;
                    m_cause = 2'(i);
                    clr[i]  = 1'b1;
                end
            end
        end
        m_ovr  = (m_ovr & ~c_clr) | (ev & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | ev;
    endtask

    // Advance one cycle: model the edge, apply the next inputs, queue the expectation.
    task automatic step(input logic r, input logic [3:0] s, input logic [3:0] i,
                        input logic a, input logic [3:0] oc);
        exp_t e;
        @(posedge clock);
        model_edge();
        #1;
        reset = r; src = s; ie = i; ack = a; ovr_clr = oc;
        c_rst = r; c_src = s; c_ie = i; c_ack = a; c_clr = oc;
        e.pend  = m_pend;
        e.ovr   = m_ovr;
        e.cause = m_cause;
        e.cv    = m_cv;
        e.irq   = |(m_pend & c_ie);
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input logic r, input logic [3:0] s, input logic [3:0] i,
                        input logic a, input logic [3:0] oc);
        for (int k = 0; k < n; k++) step(r, s, i, a, oc);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation each cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pending",     int'(pending),     int'(e.pend));
            chk("overrun",     int'(overrun),     int'(e.ovr));
            chk("cause",       int'(cause),       int'(e.cause));
            chk("cause_valid", int'(cause_valid), int'(e.cv));
            chk("irq",         int'(irq),         int'(e.irq));
        end
    end

    initial begin
        logic [3:0] rs, ri, roc;
        logic       ra, rr;
        reset = 1'b1; src = '0; ie = '0; ack = 1'b0; ovr_clr = '0;
        c_rst = 1'b1; c_src = '0; c_ie = '0; c_ack = 1'b0; c_clr = '0;
        m_pend = '0; m_ovr = '0; m_cause = '0; m_cv = 1'b0;
        m_prev = '0; m_have_prev = 1'b0;
        rise_hist[0] = '0; rise_hist[1] = '0;

        // Single source with ack.
        hold(2, 1, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(3, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0010, 4'b0010, 0, 4'b0000);
        hold(3, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 1, 4'b0000);
        hold(2, 0, 4'b0000, 4'b0010, 0, 4'b0000);

        // Simultaneous edges, priority order over two acks.
        hold(1, 0, 4'b1001, 4'b1111, 0, 4'b0000);
        hold(3, 0, 4'b0000, 4'b1111, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b1111, 1, 4'b0000);
        hold(1, 0, 4'b0000, 4'b1111, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b1111, 1, 4'b0000);
        hold(2, 0, 4'b0000, 4'b1111, 0, 4'b0000);

        // Masked source still pends; enabling raises irq at once.
        hold(1, 0, 4'b0100, 4'b0000, 0, 4'b0000);
        hold(3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        hold(2, 0, 4'b0000, 4'b0100, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0100, 1, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0100, 0, 4'b0000);

        // Overrun, overrun clear, then edge colliding with the clearing ack.
        hold(1, 0, 4'b0010, 4'b0010, 0, 4'b0000);
        hold(2, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0010, 4'b0010, 0, 4'b0000);
        hold(3, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 0, 4'b0010);
        hold(2, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0010, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 1, 4'b0000);
        hold(2, 0, 4'b0000, 4'b0010, 0, 4'b0000);

        // Clear remaining pending, then a spurious ack.
        hold(1, 0, 4'b0000, 4'b0010, 1, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b0010, 1, 4'b0000);
        hold(2, 0, 4'b0000, 4'b0010, 0, 4'b0000);

        // src held high across reset (with ack on the reset edge), then a real edge.
        hold(1, 0, 4'b0100, 4'b1111, 0, 4'b0000);
        hold(4, 0, 4'b0100, 4'b1111, 0, 4'b0000);
        hold(2, 1, 4'b0100, 4'b1111, 1, 4'b0000);
        hold(6, 0, 4'b0100, 4'b1111, 0, 4'b0000);
        hold(1, 0, 4'b0000, 4'b1111, 0, 4'b0000);
        hold(1, 0, 4'b0100, 4'b1111, 0, 4'b0000);
        hold(4, 0, 4'b0100, 4'b1111, 0, 4'b0000);

        // Randomized traffic.
        rs = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rs[b] = ~rs[b];
            end
            ri  = 4'($urandom);
            ra  = ($urandom_range(0, 3) == 0);
            roc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            rr  = ($urandom_range(0, 199) == 0);
            step(rr, rs, ri, ra, roc);
        end

        hold(3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_ctrl
